// File: rtl/pb_varint_pkg.sv
// Shared types and constants for the protobuf varint receive path.
package pb_varint_pkg;

  localparam int VARINT_MAX_BYTES = 10;

  typedef enum logic [1:0] {
    ACCUM,
    EMIT,
    DRAIN
  } varint_state_t;

  typedef logic [63:0] pb_word_t;

endpackage

// File: rtl/zigzag_unzip.sv
// Combinational varint value decode: optional zigzag, optional 32-bit
// (sint32 / int32) sign extension.
module zigzag_unzip
  import pb_varint_pkg::*;
(
  input  pb_word_t acc,
  input  logic     zz_en,
  input  logic     is_32,
  output pb_word_t out_val
);

  logic [31:0] t32;

  // Select between raw, int32, sint64 and sint32 interpretations.
  always_comb begin
    t32 = (acc[31:0] >> 1) ^ {32{acc[0]}};
    if (!zz_en) begin
      if (is_32) out_val = {{32{acc[31]}}, acc[31:0]};
      else       out_val = acc;
    end else begin
      if (is_32) out_val = {{32{t32[31]}}, t32};
      else       out_val = (acc >> 1) ^ {64{acc[0]}};
    end
  end

endmodule

// File: rtl/varint_zz_decoder.sv
// Byte-serial protobuf varint decoder with optional zigzag decode.
// Accumulates up to MAX_BYTES wire bytes into a 64-bit value, presents it on
// a valid/ready output, and flags overlong varints (resynchronising on the
// next terminating byte).
// Optional macro VARINT_ZZ_STATS_EN adds stat_vals/stat_errs counters.
//
// Handshakes: a byte transfers on a rising edge where in_valid && in_ready;
// an output transfers on a rising edge where out_valid && out_ready. out_val
// and out_err are stable while out_valid is high and not yet accepted.
module varint_zz_decoder
  import pb_varint_pkg::*;
#(
  parameter int MAX_BYTES = VARINT_MAX_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        zz_en,
  input  logic        is_32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_val,
  output logic        out_err
`ifdef VARINT_ZZ_STATS_EN
  ,
  output logic [31:0] stat_vals,
  output logic [31:0] stat_errs
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);

  varint_state_t state_q, state_d;
  pb_word_t      acc_q, acc_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  pb_word_t      out_val_q, out_val_d;
  logic          out_err_q, out_err_d;
  logic          zz_q, zz_d;
  logic          is32_q, is32_d;

  logic [6:0]    shamt;
  pb_word_t      acc_next;
  pb_word_t      dec_val;
  logic          mode_zz;
  logic          mode_32;

  // New payload bits land at 7*byte_idx; bits past 63 fall off the shift.
  always_comb begin
    shamt    = 7'(byte_idx_q) * 7'd7;
    acc_next = acc_q | (pb_word_t'(in_byte[6:0]) << shamt);
    // Byte 0 uses the live mode inputs; later bytes use the captured mode.
    mode_zz  = (byte_idx_q == 4'd0) ? zz_en : zz_q;
    mode_32  = (byte_idx_q == 4'd0) ? is_32 : is32_q;
  end

  zigzag_unzip u_unzip (
    .acc     (acc_next),
    .zz_en   (mode_zz),
    .is_32   (mode_32),
    .out_val (dec_val)
  );

  // Next-state and datapath update for the ACCUM/EMIT/DRAIN sequence.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    byte_idx_d = byte_idx_q;
    out_val_d  = out_val_q;
    out_err_d  = out_err_q;
    zz_d       = zz_q;
    is32_d     = is32_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_next;
          if (byte_idx_q == 4'd0) begin
            zz_d   = zz_en;
            is32_d = is_32;
          end
          if (!in_byte[7]) begin
            state_d    = EMIT;
            out_val_d  = dec_val;
            out_err_d  = 1'b0;
            byte_idx_d = 4'd0;
          end else if (byte_idx_q == LAST_IDX) begin
            state_d    = EMIT;
            out_val_d  = '0;
            out_err_d  = 1'b1;
            byte_idx_d = 4'd0;
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = out_err_q ? DRAIN : ACCUM;
        end
      end
      DRAIN: begin
        // Drop the tail of an overlong varint up to its terminating byte.
        if (in_valid && !in_byte[7]) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      byte_idx_q <= 4'd0;
      out_val_q  <= '0;
      out_err_q  <= 1'b0;
      zz_q       <= 1'b0;
      is32_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      byte_idx_q <= byte_idx_d;
      out_val_q  <= out_val_d;
      out_err_q  <= out_err_d;
      zz_q       <= zz_d;
      is32_q     <= is32_d;
    end
  end

  assign in_ready  = (state_q != EMIT);
  assign out_valid = (state_q == EMIT);
  assign out_val   = out_val_q;
  assign out_err   = out_err_q;

`ifdef VARINT_ZZ_STATS_EN
  logic [31:0] stat_vals_q, stat_vals_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  // Count accepted outputs, split by error flag; both wrap naturally.
  always_comb begin
    stat_vals_d = stat_vals_q;
    stat_errs_d = stat_errs_q;
    if (state_q == EMIT && out_ready) begin
      if (out_err_q) stat_errs_d = stat_errs_q + 32'd1;
      else           stat_vals_d = stat_vals_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_vals_q <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_vals_q <= stat_vals_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_vals = stat_vals_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_varint_zz_decoder.sv
// Directed bench for varint_zz_decoder.
module tb_varint_zz_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        zz_en;
  logic        is_32;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_val;
  logic        out_err;
`ifdef VARINT_ZZ_STATS_EN
  logic [31:0] stat_vals;
  logic [31:0] stat_errs;
`endif

  int total;
  int passed;

  varint_zz_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .zz_en     (zz_en),
    .is_32     (is_32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_err   (out_err)
`ifdef VARINT_ZZ_STATS_EN
    ,
    .stat_vals (stat_vals),
    .stat_errs (stat_errs)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
  endtask

  // Driver: present one byte at a falling edge, transfer on the next rising edge
  task automatic send(input logic [7:0] b, input logic zz, input logic i32);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    zz_en    = zz;
    is_32    = i32;
    @(posedge clk);
  endtask

  // Stop driving at the next falling edge (where outputs are then sampled)
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Bounded wait for out_valid, sampled on falling edges
  task automatic wait_out(input string tag);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  // Accept one output value
  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v, input logic e);
    wait_out(tag);
    check({tag, "_val"}, out_val, v);
    check({tag, "_err"}, {63'd0, out_err}, {63'd0, e});
    pop();
    check({tag, "_done"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    zz_en     = 1'b0;
    is_32     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_val", out_val, 64'd0);
    check("rst_out_err", {63'd0, out_err}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x03 as sint64 -> -2, visible exactly one cycle after acceptance
    send(8'h03, 1'b1, 1'b0);
    idle();
    check("t1_latency", {63'd0, out_valid}, 64'd1);
    check("t1_in_ready", {63'd0, in_ready}, 64'd0);
    expect_val("t1", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // 300 as a raw varint; mode inputs change on byte 1 and must be ignored
    send(8'hAC, 1'b0, 1'b0);
    send(8'h02, 1'b1, 1'b1);
    idle();
    expect_val("t2", 64'h0000_0000_0000_012C, 1'b0);

    // sint32 INT32_MIN
    send(8'hFF, 1'b1, 1'b1);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    idle();
    expect_val("t3", 64'hFFFF_FFFF_8000_0000, 1'b0);

    // int32 -1 encoded in 5 bytes, no zigzag
    send(8'hFF, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    send(8'h0F, 1'b0, 1'b1);
    idle();
    expect_val("t3b", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Legal 10-byte sint64 INT64_MIN
    for (int i = 0; i < 9; i++) send(8'hFF, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b0);
    idle();
    expect_val("t4", 64'h8000_0000_0000_0000, 1'b0);

    // Overlong varint, then drained terminator, then a normal value
    for (int i = 0; i < 10; i++) send(8'h80, 1'b0, 1'b0);
    idle();
    expect_val("t5_err", 64'd0, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    idle();
    check("t5_drop", {63'd0, out_valid}, 64'd0);
    send(8'h05, 1'b0, 1'b0);
    idle();
    expect_val("t5_ok", 64'd5, 1'b0);

    // Backpressure: output held while a competing byte is offered
    send(8'h07, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      check("bp_val", out_val, 64'd7);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
    expect_val("bp", 64'd7, 1'b0);

    // Reset mid-value discards the partial accumulation
    send(8'h80, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mr_out_valid", {63'd0, out_valid}, 64'd0);
    check("mr_out_val", out_val, 64'd0);
    check("mr_out_err", {63'd0, out_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 1'b0, 1'b0);
    idle();
    expect_val("mr", 64'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/varint_zz_decoder.md
Name: varint_zz_decoder

Overview:
- Byte-serial protobuf varint decoder with optional zigzag decode for sint32/sint64 fields. It is the receive-side inverse of the field encoder path.
- Accepts one wire byte per cycle from the field parser and accumulates up to 10 varint bytes into a 64-bit raw value.
- Optionally un-zigzags the value and presents it on a valid/ready output.
- Flags overlong varints and resynchronises on the next terminating byte.

Parameters:
- MAX_BYTES, 10, maximum varint length in bytes; a continuation bit on byte MAX_BYTES is an error.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assert, active-low
- in_valid  input  1  in_byte is valid
- in_byte  input  8  wire byte; bit7 = continuation, bits[6:0] = payload
- in_ready  output  1  byte is accepted when in_valid && in_ready
- zz_en  input  1  apply zigzag decode to this value
- is_32  input  1  sint32 semantics (decode the low 32 bits, then sign-extend)
- out_valid  output  1  out_val/out_err are valid
- out_ready  input  1  consumer accepts the output
- out_val  output  64  decoded value
- out_err  output  1  value was an overlong varint; out_val=0

Behaviour:
- Reset values: state=ACCUM, acc=0, byte_idx=0, out_valid=0, out_val=0, out_err=0.
- Reset mid-operation discards any partial value.
- zz_en and is_32 are sampled on acceptance of byte 0 of each value and held until that value is emitted.
- States:
  - ACCUM: in_ready=1. On accept, acc |= in_byte[6:0] << 7*byte_idx. Bits beyond bit 63 are discarded (10th-byte bits[6:1]).
    - in_byte[7]=0: go to EMIT. out_val = decode(acc_next). out_err=0. Reset byte_idx.
    - in_byte[7]=1 and byte_idx==MAX_BYTES-1: go to EMIT with out_err=1 and out_val=0.
    - Otherwise: byte_idx++.
  - EMIT: out_valid=1, in_ready=0. out_val/out_err are held stable until out_ready.
    - On handshake, go to DRAIN if out_err=1, otherwise to ACCUM.
    - acc is cleared on the handshake.
  - DRAIN: in_ready=1, out_valid=0. Accepted bytes are dropped.
    - The first byte with bit7=0 is dropped and the block returns to ACCUM.
- Latency: out_valid asserts the cycle after the terminating byte is accepted. Throughput is one value per (N+1) cycles for an N-byte varint, plus any backpressure.
- Decode rules:
  - zz_en=0: out_val = acc. If is_32=1, out_val = sign-extend(acc[31:0]), matching protobuf int32.
  - zz_en=1, is_32=0: out_val = (acc >> 1) ^ {64{acc[0]}}.
  - zz_en=1, is_32=1: t = (acc[31:0] >> 1) ^ {32{acc[0]}}; out_val = sign-extend(t) to 64.
- Boundary conditions:
  - A 10-byte varint whose last byte has bit7=0 is legal.
  - in_valid low mid-value: hold state indefinitely; there is no timeout.
  - out_ready high while in EMIT with no pending input: no change apart from the handshake.

Optional Feature:
- Macro VARINT_ZZ_STATS_EN.
- Defined: adds output ports stat_vals [31:0] and stat_errs [31:0].
  - They count EMIT handshakes with out_err=0 and out_err=1 respectively.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pb_varint_pkg contains:
  - localparam VARINT_MAX_BYTES=10
  - typedef enum logic [1:0] {ACCUM, EMIT, DRAIN} varint_state_t
  - typedef logic [63:0] pb_word_t
- Sub-module zigzag_unzip: combinational decode with ports (acc, zz_en, is_32) -> out_val. It is instantiated once on acc_next.

Test Plan:
- Byte 0x03, zz_en=1, is_32=0 -> one cycle later out_valid=1, out_val=0xFFFFFFFFFFFFFFFE (-2), out_err=0.
- Bytes 0xAC,0x02, zz_en=0 -> out_val=0x000000000000012C (300).
- Bytes FF,FF,FF,FF,0F, zz_en=1, is_32=1 -> out_val=0xFFFFFFFF80000000.
- Bytes FF×9 then 01, zz_en=1, is_32=0 -> out_val=0x8000000000000000. Ten bytes accepted with no error.
- Bytes 0x80×10, 0x00, then 0x05 with zz_en=0:
  - 0x80×10 -> out_err=1, out_val=0.
  - 0x00 is dropped in DRAIN.
  - 0x05 -> out_val=5, out_err=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles during EMIT -> out_val stable, in_ready=0.
  - Assert rst_n=0 after 2 bytes of 0x80,0x80 -> all outputs 0; a subsequent 0x01 yields out_val=1.
